uart_decoder: RTL
=================

UART_DECODER -- requirements
Module: UART_Decoder

Interface
REQ-001 SHALL have parameter PERIOD_WIDTH, default 20, width of the i_Period bit-period input.
REQ-002 SHALL have port i_Clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port i_Reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port i_Period  input  PERIOD_WIDTH  bit period in i_Clk cycles (217 = 115200 baud at 25 MHz).
REQ-005 SHALL have port i_UART_RX  input  1  serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port i_Ack  input  1  consumer acknowledge; clears o_Valid and o_Overrun.
REQ-007 SHALL have port o_Byte  output  8  last correctly framed received byte.
REQ-008 SHALL have port o_Valid  output  1  level; high while o_Byte holds an unacknowledged byte.
REQ-009 SHALL have port o_Overrun  output  1  sticky; a good byte arrived while o_Valid was high.
REQ-010 SHALL have port o_Framing_Error  output  1  one-cycle pulse when the stop bit samples low.
REQ-011 SHALL have port o_Busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL pass i_UART_RX through a 2-flop synchronizer, reset value 1; all sampling uses the synchronized bit rx_s.
REQ-013 SHALL latch the effective period P = max(i_Period, 4) on leaving IDLE; i_Period changes mid-frame SHALL have no effect.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-015 IDLE: when rx_s = 0 -> START, cycle counter cleared.
REQ-016 START: after floor(P/2) cycles sample rx_s; 1 -> IDLE (glitch, no output change); 0 -> DATA, counter cleared, bit index 0.
REQ-017 DATA: every P cycles sample rx_s into shift register bit[index], LSB first; after index 7 sample -> STOP.
REQ-018 STOP: after P cycles sample rx_s; 1 -> frame good, -> IDLE; 0 -> o_Framing_Error pulse, -> BREAK.
REQ-019 BREAK: stay until rx_s = 1, then -> IDLE; no new start bit SHALL be detected until the line has returned high.
REQ-020 Good frame with o_Valid = 0: o_Byte and o_Valid = 1 SHALL update on the edge following the stop sample.
REQ-021 Good frame with o_Valid = 1: o_Byte SHALL be retained (new byte discarded) and o_Overrun set to 1.
REQ-022 Framing-error frames SHALL never modify o_Byte, o_Valid or o_Overrun.
REQ-023 i_Ack high for one cycle SHALL clear o_Valid and o_Overrun on the next edge; i_Ack with o_Valid = 0 is a no-op.
REQ-024 i_Ack coincident with a good-frame load SHALL resolve as: load wins, o_Valid = 1, o_Overrun = 0.
REQ-025 Cycle counter SHALL be PERIOD_WIDTH bits, compare against P-1 (or floor(P/2)-1), and never wrap within a bit.
REQ-026 End-to-end latency from pin falling edge to o_Valid rising SHALL be 2 + floor(P/2) + 9*P + 1 cycles, +/-1.

Reset
REQ-027 i_Reset high SHALL immediately force state IDLE, o_Byte = 8'h00, o_Valid = 0, o_Overrun = 0, o_Framing_Error = 0, o_Busy = 0, synchronizer = 1, counters = 0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no output update; after release a low line is treated as a new start bit.

Verification
REQ-029 P = 217, send 8'h2A 8N1 -> o_Valid rises within REQ-026 window, o_Byte = 8'h2A, no error pulse.
REQ-030 P = 217, send 8'h55 then 8'hA3 without i_Ack -> o_Byte = 8'h55, o_Overrun = 1; i_Ack -> both cleared.
REQ-031 Low pulse of 50 cycles on idle line, P = 217 -> returns to IDLE, o_Valid stays 0, o_Busy high about 108 cycles.
REQ-032 Frame 8'hFF with stop bit held low for 3*P -> one o_Framing_Error pulse, state BREAK until line high, o_Valid stays 0.
REQ-033 Assert i_Reset during bit 4 of a frame -> outputs at reset values immediately; next full frame 8'h0F decodes correctly.
REQ-034 i_Period = 2, send frame at P = 4 -> decodes correctly (clamp); i_Ack on load cycle -> o_Valid = 1.

Source files
------------

// File: rtl/uart_decoder.sv
// -----------------------------------------------------------------------------
// uart_decoder
//    8N1 UART receiver with a run-time programmable bit period.
//    The serial line is double-flop synchronised. A start edge is qualified
//    at mid-bit, the data bits are taken LSB first at one-period spacing, and
//    the stop bit decides between a good frame and a framing error. A stop
//    bit that samples low parks the receiver in BREAK until the line idles
//    high again, so a held-low line can never look like a new start bit.
//
// Ports
//    i_Clk            system clock, all state changes on the rising edge
//    i_Reset          asynchronous, active-high reset
//    i_Period         bit period in i_Clk cycles (values below 4 act as 4)
//    i_UART_RX        serial input, idle high
//    i_Ack            consumer acknowledge, clears o_Valid and o_Overrun
//    o_Byte           last correctly framed byte
//    o_Valid          high while o_Byte holds an unacknowledged byte
//    o_Overrun        sticky: a good byte was dropped while o_Valid was high
//    o_Framing_Error  one-cycle pulse when a stop bit samples low
//    o_Busy           high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_decoder #(
   parameter int PERIOD_WIDTH = 20
) (
   input  logic                    i_Clk,
   input  logic                    i_Reset,
   input  logic [PERIOD_WIDTH-1:0] i_Period,
   input  logic                    i_UART_RX,
   input  logic                    i_Ack,
   output logic [7:0]              o_Byte,
   output logic                    o_Valid,
   output logic                    o_Overrun,
   output logic                    o_Framing_Error,
   output logic                    o_Busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } state_t;

   localparam logic [PERIOD_WIDTH-1:0] MIN_PERIOD = PERIOD_WIDTH'(4);

   state_t                  state_q,   state_d;
   logic                    rx_meta_q, rx_meta_d;
   logic                    rx_s_q,    rx_s_d;
   logic [PERIOD_WIDTH-1:0] period_q,  period_d;
   logic [PERIOD_WIDTH-1:0] cnt_q,     cnt_d;
   logic [2:0]              bit_idx_q, bit_idx_d;
   logic [7:0]              shift_q,   shift_d;
   logic [7:0]              byte_q,    byte_d;
   logic                    valid_q,   valid_d;
   logic                    overrun_q, overrun_d;
   logic                    ferr_q,    ferr_d;
   logic                    busy_q,    busy_d;

   logic                    frame_good;
   logic [PERIOD_WIDTH-1:0] period_m1;
   logic [PERIOD_WIDTH-1:0] half_m1;

   // Terminal counts for a full bit and for the mid-start-bit probe. The
   // latched period is at least 4, so neither can underflow.
   assign period_m1 = period_q - PERIOD_WIDTH'(1);
   assign half_m1   = (period_q >> 1) - PERIOD_WIDTH'(1);

   always_comb begin
      state_d    = state_q;
      rx_meta_d  = i_UART_RX;
      rx_s_d     = rx_meta_q;
      period_d   = period_q;
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      byte_d     = byte_q;
      valid_d    = valid_q;
      overrun_d  = overrun_q;
      ferr_d     = 1'b0;
      frame_good = 1'b0;

      if (i_Ack) begin
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (!rx_s_q) begin
               state_d  = ST_START;
               cnt_d    = '0;
               // Period is frozen for the whole frame from this point on.
               period_d = (i_Period < MIN_PERIOD) ? MIN_PERIOD : i_Period;
            end
         end
         ST_START: begin
            if (cnt_q == half_m1) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  state_d = ST_IDLE;      // line went back high: a glitch
               end else begin
                  state_d   = ST_DATA;
                  bit_idx_d = 3'd0;
               end
            end else begin
               cnt_d = cnt_q + PERIOD_WIDTH'(1);
            end
         end
         ST_DATA: begin
            if (cnt_q == period_m1) begin
               cnt_d            = '0;
               shift_d[bit_idx_q] = rx_s_q;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + PERIOD_WIDTH'(1);
            end
         end
         ST_STOP: begin
            if (cnt_q == period_m1) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  state_d    = ST_IDLE;
                  frame_good = 1'b1;
               end else begin
                  state_d = ST_BREAK;
                  ferr_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + PERIOD_WIDTH'(1);
            end
         end
         ST_BREAK: begin
            if (rx_s_q) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // valid_d already includes any acknowledge in this cycle, so an
      // acknowledge that coincides with a new byte frees the slot for it.
      if (frame_good) begin
         if (valid_d) begin
            overrun_d = 1'b1;
         end else begin
            byte_d    = shift_q;
            valid_d   = 1'b1;
            overrun_d = 1'b0;
         end
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state_q   <= ST_IDLE;
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         period_q  <= MIN_PERIOD;
         cnt_q     <= '0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         byte_q    <= 8'h00;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rx_meta_q <= rx_meta_d;
         rx_s_q    <= rx_s_d;
         period_q  <= period_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         byte_q    <= byte_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         ferr_q    <= ferr_d;
         busy_q    <= busy_d;
      end
   end

   assign o_Byte          = byte_q;
   assign o_Valid         = valid_q;
   assign o_Overrun       = overrun_q;
   assign o_Framing_Error = ferr_q;
   assign o_Busy          = busy_q;

endmodule
